line_scheduler: RTL and testbench

Sequencing controller for the shared `line_drawer` + `VGA_framebuffer` datapath. It accepts line-draw commands through a small FIFO and screen-clear requests on a separate input. It time-shares the single line drawer between the two, issuing coordinates, a one-cycle restart pulse and the framebuffer write/colour controls. It sits between top-level mode/command logic and the line drawer, and replaces ad-hoc per-mode FSMs with one arbitrated sequencer.

---
 rtl/line_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_line_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_scheduler.sv
// line_scheduler
//   Arbitrated sequencer that time-shares one line_drawer between queued
//   line-draw commands and full-screen clear sweeps, and drives the
//   framebuffer write enable / colour.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake into the line FIFO
//   cmd_x0..cmd_y1, cmd_color  line endpoints and colour (1 = white)
//   clear_req                level request for a full-screen clear
//   ld_start                 one-cycle restart pulse to the line_drawer
//   ld_x0..ld_y1             registered endpoints to the line_drawer
//   ld_done                  line_drawer finished the current line
//   pixel_write, pixel_color framebuffer write enable and colour
//   busy, clearing           status: not idle / clear sweep in progress
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting; pending clear wins over a queued command
// LOAD     | ld_start pulse for a queued line, endpoints valid
// DRAW     | writing line pixels until ld_done
// CLR_LOAD | ld_start pulse for one vertical clear column
// CLR_DRAW | writing black along the column until ld_done
module line_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int CW         = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [CW-1:0] cmd_x0,
    input  logic [CW-1:0] cmd_y0,
    input  logic [CW-1:0] cmd_x1,
    input  logic [CW-1:0] cmd_y1,
    input  logic          cmd_color,
    input  logic          clear_req,
    output logic          ld_start,
    output logic [CW-1:0] ld_x0,
    output logic [CW-1:0] ld_y0,
    output logic [CW-1:0] ld_x1,
    output logic [CW-1:0] ld_y1,
    input  logic          ld_done,
    output logic          pixel_write,
    output logic          pixel_color,
    output logic          busy,
    output logic          clearing
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 4 * CW + 1;
    localparam int XL = SCREEN_W - 1;
    localparam int YL = SCREEN_H - 1;
    localparam logic [CW-1:0] X_LAST   = XL[CW-1:0];
    localparam logic [CW-1:0] Y_LAST   = YL[CW-1:0];
    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_CLR_LOAD,
        S_CLR_DRAW
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [CW-1:0] col_q, col_d;
    logic          color_q, color_d;
    logic          clear_pend_q, clear_pend_d;
    logic [CW-1:0] ld_x0_q, ld_x0_d;
    logic [CW-1:0] ld_y0_q, ld_y0_d;
    logic [CW-1:0] ld_x1_q, ld_x1_d;
    logic [CW-1:0] ld_y1_q, ld_y1_d;
    logic          push;
    logic          pop;

    assign cmd_ready   = (count_q != FULL_CNT);
    assign push        = cmd_valid & cmd_ready;
    assign ld_start    = (state_q == S_LOAD) || (state_q == S_CLR_LOAD);
    assign pixel_write = (state_q == S_DRAW) || (state_q == S_CLR_DRAW);
    assign pixel_color = (state_q == S_DRAW) & color_q;
    assign busy        = (state_q != S_IDLE);
    assign clearing    = (state_q == S_CLR_LOAD) || (state_q == S_CLR_DRAW);
    assign ld_x0       = ld_x0_q;
    assign ld_y0       = ld_y0_q;
    assign ld_x1       = ld_x1_q;
    assign ld_y1       = ld_y1_q;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        color_d      = color_q;
        ld_x0_d      = ld_x0_q;
        ld_y0_d      = ld_y0_q;
        ld_x1_d      = ld_x1_q;
        ld_y1_d      = ld_y1_q;
        pop          = 1'b0;
        // Requests arriving mid-sweep are absorbed by the sweep itself.
        clear_pend_d = clear_pend_q | (clear_req & ~clearing);

        case (state_q)
            S_IDLE: begin
                if (clear_pend_q) begin
                    state_d      = S_CLR_LOAD;
                    clear_pend_d = 1'b0;
                    col_d        = '0;
                    ld_x0_d      = '0;
                    ld_x1_d      = '0;
                    ld_y0_d      = '0;
                    ld_y1_d      = Y_LAST;
                end else if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                    {ld_x0_d, ld_y0_d, ld_x1_d, ld_y1_d, color_d} = mem_q[rd_ptr_q];
                end
            end
            S_LOAD: state_d = S_DRAW;
            S_DRAW: begin
                if (ld_done) state_d = S_IDLE;
            end
            S_CLR_LOAD: state_d = S_CLR_DRAW;
            S_CLR_DRAW: begin
                if (ld_done) begin
                    if (col_q == X_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CLR_LOAD;
                        col_d   = col_q + 1'b1;
                        ld_x0_d = col_q + 1'b1;
                        ld_x1_d = col_q + 1'b1;
                        ld_y0_d = '0;
                        ld_y1_d = Y_LAST;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            col_q        <= '0;
            color_q      <= 1'b0;
            clear_pend_q <= 1'b0;
            ld_x0_q      <= '0;
            ld_y0_q      <= '0;
            ld_x1_q      <= '0;
            ld_y1_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            col_q        <= col_d;
            color_q      <= color_d;
            clear_pend_q <= clear_pend_d;
            ld_x0_q      <= ld_x0_d;
            ld_y0_q      <= ld_y0_d;
            ld_x1_q      <= ld_x1_d;
            ld_y1_q      <= ld_y1_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
    end

endmodule

// File: tb/tb_line_scheduler.sv
// Testbench for line_scheduler: per-cycle comparison against a
// transaction-level reference (command queue + phase of the current job),
// directed scenarios, and randomized traffic.
module tb_line_scheduler;

    localparam int DEPTH = 4;
    localparam int W     = 4;
    localparam int H     = 8;
    localparam int CW    = 11;

    localparam int P_IDLE = 0;
    localparam int P_LST  = 1;
    localparam int P_LDR  = 2;
    localparam int P_CST  = 3;
    localparam int P_CDR  = 4;

    typedef struct {
        logic [CW-1:0] x0, y0, x1, y1;
        logic          color;
        int            dlen;
    } cmd_t;

    typedef struct {
        cmd_t c;
        logic exp_ready;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic          cmd_color;
    logic          clear_req = 1'b0;
    logic          ld_start;
    logic [CW-1:0] ld_x0, ld_y0, ld_x1, ld_y1;
    logic          ld_done = 1'b0;
    logic          pixel_write, pixel_color, busy, clearing;

    cmd_t drv;
    assign cmd_x0    = drv.x0;
    assign cmd_y0    = drv.y0;
    assign cmd_x1    = drv.x1;
    assign cmd_y1    = drv.y1;
    assign cmd_color = drv.color;

    line_scheduler #(.FIFO_DEPTH(DEPTH), .SCREEN_W(W), .SCREEN_H(H), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .clear_req(clear_req),
        .ld_start(ld_start), .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
        .ld_done(ld_done), .pixel_write(pixel_write), .pixel_color(pixel_color),
        .busy(busy), .clearing(clearing)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference state
    cmd_t          q[$];
    cmd_t          cur;
    int            ph, col, dcnt, clen;
    bit            pend;
    logic [CW-1:0] mx0, my0, mx1, my1;
    logic          mcolor;
    bit            rnd_clen = 1'b0;

    // observation log
    int            cyc = 0, n_start = 0, n_write = 0, last_start_cyc = -1;
    bit            slog[$];
    logic [CW-1:0] line_x0[$];
    logic [CW-1:0] col_seq[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input int x0, input int y0, input int x1, input int y1,
                                input int c, input int l);
        cmd_t r;
        r.x0 = x0[CW-1:0]; r.y0 = y0[CW-1:0];
        r.x1 = x1[CW-1:0]; r.y1 = y1[CW-1:0];
        r.color = c[0]; r.dlen = l;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        ph = P_IDLE; col = 0; dcnt = 0; clen = 2; pend = 0;
        mx0 = '0; my0 = '0; mx1 = '0; my1 = '0; mcolor = 1'b0;
        cur = mk(0, 0, 0, 0, 0, 1);
    endtask

    function automatic bit in_sweep();
        return (ph == P_CST) || (ph == P_CDR);
    endfunction

    task automatic start_column(input int c);
        col = c; ph = P_CST;
        mx0 = c[CW-1:0]; mx1 = c[CW-1:0]; my0 = '0; my1 = CW'(H - 1);
        clen = rnd_clen ? int'($urandom_range(1, 3)) : 2;
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic advance();
        bit push_now, clr_acc;
        push_now = cmd_valid && (q.size() < DEPTH);
        clr_acc  = clear_req && !in_sweep();
        case (ph)
            P_IDLE: begin
                if (pend) begin
                    pend = 0;
                    start_column(0);
                end else begin
                    pend = pend | clr_acc;
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        ph = P_LST;
                        mx0 = cur.x0; my0 = cur.y0; mx1 = cur.x1; my1 = cur.y1;
                        mcolor = cur.color;
                    end
                end
            end
            P_LST: begin pend = pend | clr_acc; ph = P_LDR; dcnt = 1; end
            P_LDR: begin
                pend = pend | clr_acc;
                if (ld_done) ph = P_IDLE; else dcnt++;
            end
            P_CST: begin ph = P_CDR; dcnt = 1; end
            default: begin
                if (ld_done) begin
                    if (col == W - 1) ph = P_IDLE;
                    else start_column(col + 1);
                end else dcnt++;
            end
        endcase
        if (push_now) q.push_back(drv);
    endtask

    task automatic check_outputs();
        chk("busy",        busy,        ph != P_IDLE);
        chk("ld_start",    ld_start,    (ph == P_LST) || (ph == P_CST));
        chk("pixel_write", pixel_write, (ph == P_LDR) || (ph == P_CDR));
        chk("pixel_color", pixel_color, (ph == P_LDR) ? mcolor : 1'b0);
        chk("clearing",    clearing,    in_sweep());
        chk("cmd_ready",   cmd_ready,   q.size() < DEPTH);
        chk("ld_x0", ld_x0, mx0);
        chk("ld_y0", ld_y0, my0);
        chk("ld_x1", ld_x1, mx1);
        chk("ld_y1", ld_y1, my1);
    endtask

    task automatic step();
        advance();
        @(negedge clk);
        cyc++;
        check_outputs();
        if (ld_start) begin
            n_start++;
            last_start_cyc = cyc;
            slog.push_back(clearing);
            if (clearing) col_seq.push_back(ld_x0);
            else line_x0.push_back(ld_x0);
        end
        if (pixel_write) n_write++;
        // Drawer model; random ld_done outside draw phases must be ignored.
        if (ph == P_LDR)      ld_done = (dcnt >= cur.dlen);
        else if (ph == P_CDR) ld_done = (dcnt >= clen);
        else                  ld_done = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; clear_req = 1'b0; ld_done = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ld_start", ld_start, 0);
        chk("rst_pixel_write", pixel_write, 0);
        chk("rst_pixel_color", pixel_color, 0);
        chk("rst_clearing", clearing, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_coords", int'(ld_x0 | ld_y0 | ld_x1 | ld_y1), 0);
        model_reset();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push(input cmd_t c);
        bit acc = 0;
        drv = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            acc = (q.size() < DEPTH);
            step();
        end
        cmd_valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_for(input int want_ph, input int want_col);
        int i = 0;
        while (!(ph == want_ph && (want_col < 0 || col == want_col)) && i < 500) begin
            step();
            i++;
        end
        if (i >= 500) chk("wait_timeout", ph, want_ph);
    endtask

    task automatic drain();
        int i = 0;
        cmd_valid = 1'b0; clear_req = 1'b0;
        while (!(ph == P_IDLE && q.size() == 0 && !pend) && i < 3000) begin
            step();
            i++;
        end
        if (i >= 3000) chk("drain_timeout", ph, P_IDLE);
        repeat (2) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int   s0, w0, pc;
        int   exp_seq[7];
        cmd_t a;

        drv = mk(0, 0, 0, 0, 0, 1);
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // single line, drawer finishes in its 5th cycle
        s0 = n_start; w0 = n_write;
        push(mk(130, 140, 280, 100, 1, 5));
        pc = cyc;
        repeat (10) step();
        chk("t1_start_count", n_start - s0, 1);
        chk("t1_start_cycle", last_start_cyc, pc + 1);
        chk("t1_write_cycles", n_write - w0, 5);
        chk("t1_idle", busy, 0);

        // FIFO fill while the drawer is held in DRAW
        tbl[0] = '{mk(10, 20, 30, 40, 1, 2), 1'b1};
        tbl[1] = '{mk(11, 21, 31, 41, 0, 1), 1'b1};
        tbl[2] = '{mk(12, 22, 32, 42, 1, 3), 1'b1};
        tbl[3] = '{mk(13, 23, 33, 43, 0, 2), 1'b1};
        tbl[4] = '{mk(14, 24, 34, 44, 1, 4), 1'b0};
        line_x0.delete();
        push(mk(99, 98, 97, 96, 1, 30));
        wait_for(P_LDR, -1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_ready_%0d", i), cmd_ready, tbl[i].exp_ready);
            if (i < 4) begin
                drv = tbl[i].c; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
            end else begin
                push(tbl[i].c);
            end
        end
        drain();
        chk("t3_lines", line_x0.size(), 6);
        for (int i = 0; i < 5; i++)
            if (i + 1 < line_x0.size())
                chk($sformatf("t3_order_%0d", i), line_x0[i + 1], tbl[i].c.x0);

        // single clear sweep
        slog.delete(); col_seq.delete();
        clear_req = 1'b1; step(); clear_req = 1'b0;
        drain();
        chk("t4_columns", col_seq.size(), W);
        for (int i = 0; i < W; i++)
            if (i < col_seq.size()) chk($sformatf("t4_col_%0d", i), col_seq[i], i);
        chk("t4_clearing_end", clearing, 0);

        // clear during a line with two more queued; repeat request mid-sweep
        slog.delete();
        push(mk(1, 2, 3, 4, 1, 6));
        push(mk(5, 6, 7, 8, 0, 2));
        push(mk(9, 10, 11, 12, 1, 2));
        wait_for(P_LDR, -1);
        clear_req = 1'b1; step(); clear_req = 1'b0;
        wait_for(P_CDR, 1);
        clear_req = 1'b1; step(); clear_req = 1'b0;
        drain();
        exp_seq = '{0, 1, 1, 1, 1, 0, 0};
        chk("t5_seq_len", slog.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < slog.size()) chk($sformatf("t5_seq_%0d", i), slog[i], exp_seq[i]);

        // reset mid-sweep with commands queued
        clear_req = 1'b1; step(); clear_req = 1'b0;
        push(mk(20, 21, 22, 23, 1, 2));
        push(mk(24, 25, 26, 27, 1, 2));
        push(mk(28, 29, 30, 31, 1, 2));
        wait_for(P_CDR, 2);
        do_reset();
        s0 = n_start;
        repeat (10) step();
        chk("t6_no_start", n_start - s0, 0);
        push(mk(40, 41, 42, 43, 1, 3));
        drain();
        chk("t6_fresh_line", n_start - s0, 1);

        // simultaneous push and pop in IDLE with three entries held
        a = mk(50, 51, 52, 53, 1, 20);
        push(a);
        wait_for(P_LDR, -1);
        push(mk(60, 61, 62, 63, 0, 1));
        push(mk(64, 65, 66, 67, 1, 2));
        push(mk(68, 69, 70, 71, 0, 1));
        wait_for(P_IDLE, -1);
        chk("t7_ready_before", cmd_ready, 1);
        drv = mk(72, 73, 74, 75, 1, 2); cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
        chk("t7_ready_after_pp", cmd_ready, 1);
        drv = mk(76, 77, 78, 79, 0, 1); cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
        chk("t7_full", cmd_ready, 0);
        drain();

        // randomized traffic
        rnd_clen = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 9) < 3);
            drv = mk($urandom_range(0, 2047), $urandom_range(0, 2047),
                     $urandom_range(0, 2047), $urandom_range(0, 2047),
                     $urandom_range(0, 1), $urandom_range(1, 4));
            clear_req = ($urandom_range(0, 99) < 2);
            step();
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
